// File: rtl/ssd_count_sequencer.sv
// Display-state sequencer: steps a 4-bit value between 0 and MAX_STATE at a
// programmable rate with one-shot/loop runs, pause/resume and an IDLE blank flag.
module ssd_count_sequencer #(
  parameter int unsigned DIV       = 50000000,
  parameter int unsigned CW        = 26,
  parameter int unsigned MAX_STATE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_loop,
  input  logic       dir,
  output logic [3:0] state_out,
  output logic       step_pulse,
  output logic       busy,
  output logic       done,
  output logic       blank
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] TICK_AT = CW'(DIV - 1);
  localparam logic [3:0]    TOP     = 4'(MAX_STATE);

  logic [1:0]    fsm_q, fsm_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [3:0]    val_d;
  logic          pulse_d;
  logic          hold_q, hold_d;
  logic          tick;

  assign tick = (pre_q == TICK_AT);

  // State register and registered outputs, all derived from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      pre_q      <= '0;
      hold_q     <= 1'b0;
      state_out  <= 4'd0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      blank      <= 1'b1;
    end else begin
      fsm_q      <= fsm_d;
      pre_q      <= pre_d;
      hold_q     <= hold_d;
      state_out  <= val_d;
      step_pulse <= pulse_d;
      busy       <= (fsm_d == RUN) || (fsm_d == PAUSE);
      done       <= (fsm_d == DONE);
      blank      <= (fsm_d == IDLE);
    end
  end

  // Next-state, prescaler and step logic; priority is stop > start > tick
  always_comb begin
    fsm_d   = fsm_q;
    pre_d   = pre_q;
    val_d   = state_out;
    pulse_d = 1'b0;
    hold_d  = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start && !stop) begin
          fsm_d = RUN;
          pre_d = '0;
          val_d = dir ? TOP : 4'd0;
        end
      end

      RUN: begin
        if (stop) begin
          fsm_d = PAUSE;
        end else if (tick) begin
          pre_d = '0;
          if (!dir) begin
            if (state_out < TOP) begin
              val_d   = state_out + 4'd1;
              pulse_d = 1'b1;
            end else if (mode_loop) begin
              val_d   = 4'd0;
              pulse_d = 1'b1;
            end else begin
              fsm_d = DONE;
            end
          end else begin
            if (state_out != 4'd0) begin
              val_d   = state_out - 4'd1;
              pulse_d = 1'b1;
            end else if (mode_loop) begin
              val_d   = TOP;
              pulse_d = 1'b1;
            end else begin
              fsm_d = DONE;
            end
          end
        end else begin
          pre_d = pre_q + CW'(1);
        end
      end

      PAUSE: begin
        // hold_q remembers stop from the previous PAUSE cycle; a second one aborts
        if (stop) begin
          if (hold_q) begin
            fsm_d = IDLE;
            pre_d = '0;
            val_d = 4'd0;
          end else begin
            hold_d = 1'b1;
          end
        end else if (start) begin
          fsm_d = RUN;
        end
      end

      DONE: begin
        if (stop) begin
          fsm_d = IDLE;
          pre_d = '0;
          val_d = 4'd0;
        end else if (start) begin
          fsm_d = RUN;
          pre_d = '0;
          val_d = dir ? TOP : 4'd0;
        end
      end

      default: begin
        fsm_d = IDLE;
        pre_d = '0;
        val_d = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ssd_count_sequencer.sv
// Bench for ssd_count_sequencer: a DIV=4 instance for run/pause/direction tests
// and a DIV=1 instance for the reset/start+stop table.
module tb_ssd_count_sequencer;

  typedef struct packed {
    logic [3:0] st;
    logic       sp;
    logic       busy;
    logic       done;
    logic       blank;
  } exp_t;

  typedef struct {
    logic rst_n;
    logic start;
    logic stop;
    logic ml;
    logic dir;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, mode_loop, dir;
  logic [3:0] a_st, b_st;
  logic a_sp, a_busy, a_done, a_blank;
  logic b_sp, b_busy, b_done, b_blank;

  int checks = 0;
  int errors = 0;
  int v = 0;
  int pulse_cnt = 0;
  logic sel_b = 1'b0;
  exp_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  ssd_count_sequencer #(.DIV(4), .CW(26), .MAX_STATE(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_loop(mode_loop), .dir(dir),
    .state_out(a_st), .step_pulse(a_sp), .busy(a_busy), .done(a_done), .blank(a_blank)
  );

  ssd_count_sequencer #(.DIV(1), .CW(26), .MAX_STATE(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_loop(mode_loop), .dir(dir),
    .state_out(b_st), .step_pulse(b_sp), .busy(b_busy), .done(b_done), .blank(b_blank)
  );

  always @(negedge clk) begin
    if (a_sp === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1);
  end

  function automatic exp_t ex(int st, logic sp, logic b, logic d, logic bl);
    exp_t r;
    r.st = 4'(st); r.sp = sp; r.busy = b; r.done = d; r.blank = bl;
    return r;
  endfunction

  function automatic vec_t mkv(logic r, logic s, logic p, logic ml, logic d, exp_t e);
    vec_t x;
    x.rst_n = r; x.start = s; x.stop = p; x.ml = ml; x.dir = d; x.e = e;
    return x;
  endfunction

  task automatic check_out(input string nm);
    exp_t e, act;
    e = exp_q.pop_front();
    act = sel_b ? {b_st, b_sp, b_busy, b_done, b_blank} : {a_st, a_sp, a_busy, a_done, a_blank};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d sp=%b busy=%b done=%b blank=%b, expected state=%0d sp=%b busy=%b done=%b blank=%b",
               nm, act.st, act.sp, act.busy, act.done, act.blank, e.st, e.sp, e.busy, e.done, e.blank);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare
  task automatic cyc(input logic r, input logic s, input logic p, input logic ml, input logic d,
                     input exp_t e, input string nm);
    rst_n = r; start = s; stop = p; mode_loop = ml; dir = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  // n prescaler periods on DUT A (DIV=4), none of which may end the run
  task automatic run_ticks(input int n, input logic ml, input logic d, input logic s, input string nm);
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 3; k++) cyc(1'b1, s, 1'b0, ml, d, ex(v, 1'b0, 1'b1, 1'b0, 1'b0), nm);
      if (!d) v = (v == 10) ? 0 : v + 1;
      else    v = (v == 0) ? 10 : v - 1;
      cyc(1'b1, s, 1'b0, ml, d, ex(v, 1'b1, 1'b1, 1'b0, 1'b0), nm);
    end
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0; dir = 1'b0;

    // DIV=1 table: reset, steps every cycle, mid-run reset, start+stop stays IDLE
    tbl.push_back(mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1)));
    tbl.push_back(mkv(1, 1, 0, 1, 0, ex(0, 0, 1, 0, 0)));
    for (int i = 1; i <= 5; i++) tbl.push_back(mkv(1, 0, 0, 1, 0, ex(i, 1, 1, 0, 0)));
    tbl.push_back(mkv(0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1)));
    tbl.push_back(mkv(1, 1, 1, 1, 0, ex(0, 0, 0, 0, 1)));
    tbl.push_back(mkv(1, 1, 1, 1, 0, ex(0, 0, 0, 0, 1)));
    tbl.push_back(mkv(1, 1, 0, 1, 1, ex(10, 0, 1, 0, 0)));
    tbl.push_back(mkv(1, 0, 0, 1, 1, ex(9, 1, 1, 0, 0)));

    sel_b = 1'b1;
    foreach (tbl[i])
      cyc(tbl[i].rst_n, tbl[i].start, tbl[i].stop, tbl[i].ml, tbl[i].dir, tbl[i].e,
          $sformatf("t5 row %0d", i));

    sel_b = 1'b0;
    cyc(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1), "reset A");
    cyc(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1), "idle A");

    // Test 1: one-shot up, ends in DONE at 10
    p0 = pulse_cnt;
    cyc(1, 1, 0, 0, 0, ex(0, 0, 1, 0, 0), "t1 load");
    v = 0;
    run_ticks(10, 1'b0, 1'b0, 1'b0, "t1 step");
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, ex(10, 0, 1, 0, 0), "t1 pre-done");
    cyc(1, 0, 0, 0, 0, ex(10, 0, 0, 1, 0), "t1 done");
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, ex(10, 0, 0, 1, 0), "t1 hold");
    checks++;
    if (pulse_cnt - p0 != 10) begin
      errors++;
      $display("FAIL t1 pulse count: got %0d, expected 10", pulse_cnt - p0);
    end
    cyc(1, 0, 1, 0, 0, ex(0, 0, 0, 0, 1), "t1 stop idle");

    // Test 2: looping up with start held high; wraps 10 -> 0 without reload
    cyc(1, 1, 0, 1, 0, ex(0, 0, 1, 0, 0), "t2 load");
    v = 0;
    run_ticks(12, 1'b1, 1'b0, 1'b1, "t2 step");
    cyc(1, 0, 1, 1, 0, ex(1, 0, 1, 0, 0), "t2 pause");
    cyc(1, 0, 1, 1, 0, ex(1, 0, 1, 0, 0), "t2 pause hold");
    cyc(1, 0, 1, 1, 0, ex(0, 0, 0, 0, 1), "t2 abort");

    // Test 3: one-shot down from 10 to DONE at 0
    cyc(1, 1, 0, 0, 1, ex(10, 0, 1, 0, 0), "t3 load");
    v = 10;
    run_ticks(10, 1'b0, 1'b1, 1'b0, "t3 step");
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, ex(0, 0, 1, 0, 0), "t3 pre-done");
    cyc(1, 0, 0, 0, 1, ex(0, 0, 0, 1, 0), "t3 done");
    cyc(1, 0, 0, 0, 1, ex(0, 0, 0, 1, 0), "t3 hold");
    cyc(1, 0, 1, 0, 1, ex(0, 0, 0, 0, 1), "t3 stop idle");

    // Test 4: pause two cycles after a step; prescaler resumes from frozen value
    cyc(1, 1, 0, 1, 0, ex(0, 0, 1, 0, 0), "t4 load");
    v = 0;
    run_ticks(1, 1'b1, 1'b0, 1'b0, "t4 step");
    cyc(1, 0, 0, 1, 0, ex(1, 0, 1, 0, 0), "t4 cnt1");
    cyc(1, 0, 0, 1, 0, ex(1, 0, 1, 0, 0), "t4 cnt2");
    cyc(1, 0, 1, 1, 0, ex(1, 0, 1, 0, 0), "t4 pause");
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 1, 0, ex(1, 0, 1, 0, 0), "t4 paused");
    cyc(1, 1, 0, 1, 0, ex(1, 0, 1, 0, 0), "t4 resume");
    cyc(1, 0, 0, 1, 0, ex(1, 0, 1, 0, 0), "t4 resume+1");
    cyc(1, 0, 0, 1, 0, ex(2, 1, 1, 0, 0), "t4 resume step");
    v = 2;
    run_ticks(1, 1'b1, 1'b0, 1'b0, "t4 cadence");
    cyc(1, 0, 1, 1, 0, ex(3, 0, 1, 0, 0), "t4 stop");
    cyc(1, 0, 1, 1, 0, ex(3, 0, 1, 0, 0), "t4 stop2");
    cyc(1, 0, 1, 1, 0, ex(0, 0, 0, 0, 1), "t4 abort");

    // Test 6: flip dir mid-prescale at state 3; then abort from PAUSE
    cyc(1, 1, 0, 1, 0, ex(0, 0, 1, 0, 0), "t6 load");
    v = 0;
    run_ticks(3, 1'b1, 1'b0, 1'b0, "t6 step");
    cyc(1, 0, 0, 1, 0, ex(3, 0, 1, 0, 0), "t6 cnt1");
    cyc(1, 0, 0, 1, 1, ex(3, 0, 1, 0, 0), "t6 dir cnt2");
    cyc(1, 0, 0, 1, 1, ex(3, 0, 1, 0, 0), "t6 dir cnt3");
    cyc(1, 0, 0, 1, 1, ex(2, 1, 1, 0, 0), "t6 down step");
    cyc(1, 0, 1, 1, 1, ex(2, 0, 1, 0, 0), "t6 pause");
    cyc(1, 0, 1, 1, 1, ex(2, 0, 1, 0, 0), "t6 stop1");
    cyc(1, 0, 1, 1, 1, ex(0, 0, 0, 0, 1), "t6 abort");
    cyc(1, 0, 0, 1, 1, ex(0, 0, 0, 0, 1), "t6 idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_count_sequencer.md
Name: ssd_count_sequencer

Overview:
Sequencer for the 4-bit display-state path feeding the HEX-digit decoders. It steps a state value from 0000 to 1010 (or down from 1010 to 0000) at a programmable rate derived from the board clock. It supports one-shot and looping runs, pause/resume, and a blank indication for IDLE. Its state_out drives the decoder input directly; blank is used by top level to force the segments off.

Parameters:
DIV, 50000000, clock cycles per state step; legal range 1 to 2^CW-1.
CW, 26, prescaler counter width.
MAX_STATE, 10, terminal state value; legal range 1 to 15. The default gives the 0000..1010 sequence.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  level; start, restart or resume (see FSM).
stop  input  1  level; pause, or abort to IDLE.
mode_loop  input  1  1 = wrap at terminal; 0 = one-shot, stop in DONE.
dir  input  1  0 = count up, 1 = count down.
state_out  output  4  current state to decoder; never exceeds MAX_STATE.
step_pulse  output  1  one-cycle high in the cycle state_out takes a new stepped value.
busy  output  1  high in RUN and PAUSE.
done  output  1  high while in DONE.
blank  output  1  high in IDLE; top level blanks the digit.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n).
- All outputs are registered.
- Reset values, applied on any clk edge with rst_n=0 (including mid-run):
  - FSM = IDLE, state_out = 0, prescaler = 0.
  - step_pulse = 0, busy = 0, done = 0, blank = 1.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Priority within a cycle: reset > stop > start > tick.
- IDLE:
  - start=1 and stop=0 -> RUN.
  - On entry to RUN: state_out loads 0 if dir=0, MAX_STATE if dir=1; prescaler cleared.
  - The load does not assert step_pulse.
- RUN:
  - Prescaler counts 0..DIV-1. tick = (prescaler == DIV-1), after which the prescaler returns to 0.
  - First step occurs exactly DIV cycles after entering RUN. DIV=1 steps every cycle.
  - On tick with dir=0: state < MAX_STATE -> state+1. At MAX_STATE: mode_loop=1 -> 0; mode_loop=0 -> DONE, state held at MAX_STATE.
  - On tick with dir=1: state > 0 -> state-1. At 0: mode_loop=1 -> MAX_STATE; mode_loop=0 -> DONE, state held at 0.
  - step_pulse=1 only on ticks that change state_out. It is not asserted on the tick that enters DONE.
  - dir and mode_loop are sampled every tick. Changing them mid-run affects the next tick only; no reload occurs.
  - stop=1 -> PAUSE. Prescaler and state are frozen; a tick in the same cycle is discarded.
- PAUSE:
  - start=1 and stop=0 -> RUN, resuming the prescaler from its frozen value (no reload).
  - stop=1 held for 2 consecutive cycles in PAUSE -> IDLE (abort). state_out is cleared to 0 on entry to IDLE.
- DONE:
  - done=1 and state_out is held.
  - start=1 -> RUN with a fresh load exactly as from IDLE.
  - stop=1 -> IDLE.
- Entry to IDLE from any state: state_out=0, prescaler=0.
- Output encoding:
  - busy = (RUN | PAUSE).
  - blank = IDLE.
  - All outputs are mutually consistent in the same cycle.
- start held high continuously does not re-trigger a load while in RUN. It is level-sensitive only in IDLE, PAUSE and DONE.
- Width rules:
  - Prescaler compare at CW bits.
  - State arithmetic is 4-bit; no out-of-range value (>MAX_STATE) is ever produced.

Test Plan:
1. DIV=4, MAX_STATE=10, dir=0, mode_loop=0; pulse start 1 cycle -> state_out steps 0,1,...,10, one step every 4 cycles with step_pulse each step; done=1 and state_out held at 10 thereafter (10 step_pulses total).
2. DIV=4, dir=0, mode_loop=1; run 12 ticks -> state_out sequence 1..10, then 0, 1; busy=1 throughout, done never asserts.
3. DIV=4, dir=1, mode_loop=0; start -> state_out loads 10, steps down to 0, then DONE; stop -> IDLE with blank=1 and state_out=0.
4. DIV=4; stop for 1 cycle 2 cycles after a step, hold 10 cycles, then start -> no step while paused; next step occurs exactly 2 cycles after resume (prescaler frozen, not reset).
5. DIV=1, RUN at state 5: assert rst_n=0 for 1 cycle -> next cycle IDLE, state_out=0, busy=0, blank=1, step_pulse=0. Then start and stop asserted together -> remains IDLE.
6. DIV=4, RUN at state 3: switch dir to 1 mid-prescale -> next tick gives state_out=2 with no reload. Then in PAUSE hold stop for 2 cycles -> IDLE.
